// File: rtl/rng_pkg.sv
// ============================================================================
// Module   : rng_pkg
// Purpose  : Shared types, LFSR taps and step function for the RNG scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } rng_state_e;

  localparam int          LFSR_TAP_3 = 23;
  localparam int          LFSR_TAP_2 = 17;
  localparam int          LFSR_TAP_1 = 5;
  localparam int          LFSR_TAP_0 = 0;
  localparam logic [23:0] SEED_MASK  = 24'hFFFFFF;

  typedef logic [31:0] q8_24_t;

  // 24-bit Fibonacci LFSR held in the fraction field; integer byte stays zero.
  function automatic q8_24_t lfsr_step(input q8_24_t s);
    logic fb;
    fb = s[LFSR_TAP_3] ^ s[LFSR_TAP_2] ^ s[LFSR_TAP_1] ^ s[LFSR_TAP_0];
    return {8'h00, s[22:0], fb};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rng_lfsr_32.sv
// ============================================================================
// Module   : rng_lfsr_32
// Purpose  : LFSR datapath register with synchronous load and step enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rng_lfsr_32
  import rng_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_i,
  input  q8_24_t seed_i,
  input  logic   en_i,
  output q8_24_t state_o
);

  q8_24_t state_q;
  q8_24_t state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/rng_scheduler.sv
// ============================================================================
// Module   : rng_scheduler
// Purpose  : Seeds/warms an LFSR and hands out one word per round-robin grant.
//            Optional RNG_SCHEDULER_STATS_EN adds the draw_count output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rng_scheduler
  import rng_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output q8_24_t             rand_out,
  output logic               rand_valid,
  output logic               ready
`ifdef RNG_SCHEDULER_STATS_EN
  ,
  output logic [31:0]        draw_count
`endif
);

  localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  rng_state_e         state_q;
  rng_state_e         state_d;
  logic [23:0]        seed_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [7:0]         warm_cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  q8_24_t             rand_out_q;
  logic               rand_valid_q;
  logic               ready_q;

  q8_24_t             lfsr_state;
  logic               step;
  logic               warm_step;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] gnt_d;
  logic               unused_seed_hi;

  assign unused_seed_hi = ^seed[31:24];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEED;
      ST_SEED:   state_d = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
      ST_WARMUP: if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
      ST_RUN:    if (start) state_d = ST_SEED;
      default:   state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
    end
  end

  // A grant only happens when RUN persists into the next cycle (no stop/start).
  assign step      = (state_q == ST_RUN) && (state_d == ST_RUN) && (|req);
  assign warm_step = (state_q == ST_WARMUP) && !stop;

  always_comb begin
    int               j;
    logic [PTR_W-1:0] jj;
    j          = 0;
    jj         = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      jj = PTR_W'(j);
      if (!pick_found && req[jj]) begin
        pick_found = 1'b1;
        pick_idx   = jj;
      end
    end
    ptr_nxt = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    gnt_d   = NUM_REQ'(1) << pick_idx;
  end

  rng_lfsr_32 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (state_q == ST_SEED),
    .seed_i  ({8'h00, seed_q}),
    .en_i    (step | warm_step),
    .state_o (lfsr_state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      seed_q       <= '0;
      ptr_q        <= '0;
      warm_cnt_q   <= '0;
      gnt_q        <= '0;
      rand_out_q   <= '0;
      rand_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= (state_d == ST_RUN);
      gnt_q        <= step ? gnt_d : '0;
      rand_valid_q <= step;
      if (step) begin
        rand_out_q <= lfsr_state;
        ptr_q      <= ptr_nxt;
      end
      if (state_d == ST_SEED) begin
        seed_q <= seed[23:0] & SEED_MASK;
      end
      if (state_q == ST_SEED) begin
        warm_cnt_q <= '0;
      end else if (warm_step) begin
        warm_cnt_q <= warm_cnt_q + 8'd1;
      end
    end
  end

  assign gnt        = gnt_q;
  assign rand_out   = rand_out_q;
  assign rand_valid = rand_valid_q;
  assign ready      = ready_q;

`ifdef RNG_SCHEDULER_STATS_EN
  logic [31:0] draw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_q <= '0;
    end else if (state_q == ST_SEED) begin
      draw_q <= '0;
    end else if (rand_valid_q && (draw_q != 32'hFFFF_FFFF)) begin
      draw_q <= draw_q + 32'd1;
    end
  end

  assign draw_count = draw_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rng_scheduler.sv
// ============================================================================
// Module   : tb_rng_scheduler
// Purpose  : Directed self-checking bench for rng_scheduler (WARMUP_CYCLES=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rng_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [31:0] seed;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rand_out;
  logic        rand_valid;
  logic        ready;
`ifdef RNG_SCHEDULER_STATS_EN
  logic [31:0] draw_count;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_s;

  always #5 clk = ~clk;

  rng_scheduler #(
    .NUM_REQ       (4),
    .WARMUP_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .seed       (seed),
    .req        (req),
    .gnt        (gnt),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .ready      (ready)
`ifdef RNG_SCHEDULER_STATS_EN
    ,
    .draw_count (draw_count)
`endif
  );

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic fb;
    fb = s[23] ^ s[17] ^ s[5] ^ s[0];
    return {8'h00, s[22:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic grant_chk(input logic [3:0] r, input logic [3:0] eg, input string tag);
    req = r;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_vld"}, 32'(rand_valid), 32'd1);
    chk({tag, "_word"}, rand_out, exp_s);
    exp_s = ref_step(exp_s);
  endtask

  // Pulse start with seed s, then wait through SEED and two warm-up cycles.
  task automatic seed_run(input logic [31:0] s, input string tag);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_seed_rdy"}, 32'(ready), 32'd0);
    tick();
    tick();
    chk({tag, "_warm_rdy"}, 32'(ready), 32'd0);
    tick();
    chk({tag, "_run_rdy"}, 32'(ready), 32'd1);
    exp_s = ref_step(ref_step({8'h00, s[23:0]}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    seed    = '0;
    req     = '0;
    exp_s   = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(rand_valid), 32'd0);
    chk("rst_word", rand_out, 32'd0);
    chk("rst_rdy", 32'(ready), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_rdy", 32'(ready), 32'd0);

    // seed=1, two warm-up steps: 1 -> 3 -> 7
    seed_run(32'h0000_0001, "s1");
    chk("s1_model", exp_s, 32'h0000_0007);
    grant_chk(4'b0001, 4'b0001, "w1");
    chk("w1_const", rand_out, 32'h0000_0007);
    grant_chk(4'b0001, 4'b0001, "w2");
    chk("w2_const", rand_out, 32'h0000_000F);
    req = 4'b0000;
    tick();
    chk("norq_gnt", 32'(gnt), 32'd0);
    chk("norq_vld", 32'(rand_valid), 32'd0);

    // pointer sits at 1; a grant to 3 wraps it back to 0
    grant_chk(4'b1000, 4'b1000, "wrap");
    for (int i = 0; i < 8; i++) begin
      grant_chk(4'b1111, 4'(4'b0001 << (i % 4)), "rr4");
    end
    req = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      grant_chk(4'b0101, (i % 2 == 1) ? 4'b0100 : 4'b0001, "rr2");
    end

    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_gnt", 32'(gnt), 32'd0);
    end
    grant_chk(4'b0101, 4'b0001, "after_gap");

    // async reset while gnt=0010
    grant_chk(4'b0010, 4'b0010, "pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_vld", 32'(rand_valid), 32'd0);
    chk("arst_rdy", 32'(ready), 32'd0);
    chk("arst_word", rand_out, 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'd0);
    chk("post_rst_rdy", 32'(ready), 32'd0);
    req = 4'b0000;

    // start during WARMUP must not disturb warm-up or seed
    seed  = 32'hAB12_3456;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    seed  = 32'h00FF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wstart_rdy0", 32'(ready), 32'd0);
    tick();
    chk("wstart_rdy1", 32'(ready), 32'd1);
    exp_s = ref_step(ref_step(32'h0012_3456));
    grant_chk(4'b0001, 4'b0001, "wstart_w");

    // start+stop together in RUN: stop wins
    req   = 4'b0001;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_gnt", 32'(gnt), 32'd0);
    chk("ss_vld", 32'(rand_valid), 32'd0);
    chk("ss_rdy", 32'(ready), 32'd0);
    tick();
    tick();
    tick();
    chk("ss_idle_rdy", 32'(ready), 32'd0);
    chk("ss_idle_gnt", 32'(gnt), 32'd0);
    req = 4'b0000;

    // all-zero low seed locks the LFSR at zero
    seed_run(32'hFF00_0000, "z");
    grant_chk(4'b0001, 4'b0001, "zero_w");
    chk("zero_const", rand_out, 32'd0);

    // re-seed from RUN keeps the pointer (now 1)
    req   = 4'b0001;
    seed  = 32'h0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_gnt", 32'(gnt), 32'd0);
    chk("rs_rdy", 32'(ready), 32'd0);
    tick();
    tick();
    chk("rs_warm_gnt", 32'(gnt), 32'd0);
    tick();
    chk("rs_run_rdy", 32'(ready), 32'd1);
    exp_s = 32'h0000_0007;
    grant_chk(4'b1111, 4'b0010, "keep_ptr");
    req = 4'b0000;
    tick();

`ifdef RNG_SCHEDULER_STATS_EN
    seed  = 32'h0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("dc_clear", draw_count, 32'd0);
    tick();
    tick();
    exp_s = 32'h0000_0007;
    for (int i = 0; i < 20; i++) begin
      grant_chk(4'b0001, 4'b0001, "dc_w");
    end
    req = 4'b0000;
    tick();
    tick();
    chk("dc_20", draw_count, 32'd20);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("dc_reseed", draw_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rng_scheduler.md
RNG_SCHEDULER -- requirements
Module: rng_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the RNG, range 2..8.
REQ-002 Parameter WARMUP_CYCLES, default 16: number of LFSR steps discarded after seeding, range 0..255.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse; load seed and begin warm-up.
REQ-006 stop  in  1  one-cycle pulse; return to IDLE.
REQ-007 seed  in  32  seed value, sampled in the cycle start is high.
REQ-008 req  in  NUM_REQ  level request per requester; one word is delivered per grant.
REQ-009 gnt  out  NUM_REQ  registered one-hot grant; at most one bit is high.
REQ-010 rand_out  out  32  Q8.24 random word, valid when rand_valid is high.
REQ-011 rand_valid  out  1  high exactly when gnt is non-zero.
REQ-012 ready  out  1  high while in RUN.

Function
REQ-013 The FSM SHALL have states IDLE, SEED, WARMUP and RUN.
REQ-014 IDLE goes to SEED on start; SEED goes to WARMUP after one cycle, or to RUN if WARMUP_CYCLES=0.
REQ-015 WARMUP goes to RUN after WARMUP_CYCLES cycles, with the LFSR advancing once per cycle.
REQ-016 In SEED the LFSR state SHALL be loaded with {8'h00, seed[23:0]}, using the value latched on start.
REQ-017 LFSR step: fb = s[23]^s[17]^s[5]^s[0]; next = {8'h00, s[22:0], fb}.
REQ-018 In RUN, if any req bit is high in cycle n, then in cycle n+1 exactly one gnt bit SHALL be high, rand_valid=1, and rand_out SHALL equal the LFSR state before the step.
REQ-019 The LFSR SHALL step only on grant cycles in RUN. With no req, the state SHALL hold and gnt=0.
REQ-020 Arbitration SHALL be round-robin. The pointer is 0 after reset; after granting i, the highest priority moves to (i+1) mod NUM_REQ.
REQ-021 In RUN, a requester holding req continuously SHALL receive a grant every cycle it wins arbitration. No word is ever delivered twice.
REQ-022 stop in any state SHALL go to IDLE next cycle, clearing gnt and rand_valid.
REQ-023 If stop and start are high together, stop SHALL win.
REQ-024 start in RUN SHALL re-seed: gnt is cleared, the FSM goes to SEED, and the arbiter pointer is kept.
REQ-025 start in SEED or WARMUP SHALL be ignored.
REQ-026 req outside RUN SHALL be ignored; no grant is queued.
REQ-027 A seed with seed[23:0]=0 SHALL be loaded as is; the LFSR stays at 0 and rand_out=0. Avoiding this is the requester's responsibility.

Reset
REQ-028 While reset_n=0, the block SHALL be in IDLE with gnt=0, rand_valid=0, rand_out=0, ready=0, LFSR state=0, pointer=0 and warm-up counter=0.
REQ-029 Asserting reset_n mid-operation SHALL take effect immediately and asynchronously. Any in-flight grant is dropped.
REQ-030 After reset_n deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-031 With macro RNG_SCHEDULER_STATS_EN defined, the block SHALL add output draw_count[31:0].
- draw_count is cleared by reset and by SEED, and increments on each rand_valid cycle.
- It saturates at 32'hFFFFFFFF.
REQ-032 Without RNG_SCHEDULER_STATS_EN, the draw_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 A shared package rng_pkg SHALL hold:
- the FSM state enum;
- the LFSR tap constants (23, 17, 5, 0);
- the seed mask 24'hFFFFFF;
- the Q8.24 word typedef.
REQ-034 The LFSR datapath SHALL be the existing sub-module rng_lfsr_32, with en driven by the step strobe and seed loading driven by the SEED state.
REQ-035 The arbiter and FSM SHALL reside in rng_scheduler; there is no other sub-module.

Verification
REQ-036 WARMUP_CYCLES=2, seed=32'h00000001, start, then req=0001 in RUN -> first word rand_out=32'h00000007 on gnt=0001, second word 32'h0000000F.
REQ-037 req=4'b1111 held for 8 RUN cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; 8 distinct words matching the REQ-017 model.
REQ-038 req=4'b0101 held -> gnt alternates 0001,0100; a req gap of 3 cycles -> the LFSR state is unchanged across the gap.
REQ-039 reset_n pulled low for 1 ns mid-RUN while gnt=0010 -> gnt=0, rand_valid=0, ready=0 immediately; IDLE after release.
REQ-040 start and stop high together in RUN -> IDLE next cycle; start alone in WARMUP -> warm-up count unaffected.
REQ-041 With RNG_SCHEDULER_STATS_EN defined, 20 grants -> draw_count=20; a re-seed via start -> draw_count=0.
